// File: rtl/pipe_pkg.sv
// Shared defaults and state encoding for the generic pipeline stage register.
package pipe_pkg;

    localparam int INS_W_DEF  = 32;
    localparam int PC_W_DEF   = 12;
    localparam int DATA_W_DEF = 32;

    localparam logic [31:0] NOP_INS_DEF = 32'h0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipeState_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: a valid bit plus a payload register.
module pipe_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] dIn,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Clear only drops the valid bit; the payload keeps its stale value.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= dIn;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready handshake, optional skid slot,
// flush-to-bubble and NOP instruction injection while empty.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 INS_W    = INS_W_DEF,
    parameter int                 PC_W     = PC_W_DEF,
    parameter int                 DATA_W   = DATA_W_DEF,
    parameter int                 NUM_DATA = 2,
    parameter int                 FLAG_W   = 3,
    parameter logic [INS_W-1:0]   NOP_INS  = INS_W'(NOP_INS_DEF),
    parameter int                 SKID     = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INS_W-1:0]           in_ins,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [FLAG_W-1:0]          in_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INS_W-1:0]           out_ins,
    output logic [PC_W-1:0]            out_pc,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [FLAG_W-1:0]          out_flags,
    output logic [1:0]                 occupancy
);

    localparam int DATA_ALL = NUM_DATA * DATA_W;
    localparam int PAY_W    = INS_W + PC_W + DATA_ALL + FLAG_W;
    localparam int PC_LSB   = DATA_ALL + FLAG_W;

    pipeState_t       state, stateNext;
    logic             inReadyReg;
    logic             inFire, outFire;
    logic             mainValid, skidValid;
    logic             mainLoad, mainClear, skidLoad, skidClear;
    logic [PAY_W-1:0] inPayload, mainD, mainQ, skidQ;

    assign inPayload = {in_ins, in_pc, in_data, in_flags};

    // With the skid slot the ready is a pure flop; without it ready looks through to out_ready.
    assign in_ready = (SKID != 0) ? inReadyReg : (!mainValid || out_ready);
    assign inFire   = in_valid && in_ready;
    assign outFire  = mainValid && out_ready;

    always_comb begin
        stateNext = state;
        mainLoad  = 1'b0;
        mainClear = 1'b0;
        skidLoad  = 1'b0;
        skidClear = 1'b0;
        mainD     = inPayload;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
            stateNext = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (inFire) begin
                        mainLoad  = 1'b1;
                        stateNext = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (inFire && outFire) begin
                        mainLoad = 1'b1;
                    end else if (inFire) begin
                        skidLoad  = 1'b1;
                        stateNext = ST_FULL;
                    end else if (outFire) begin
                        mainClear = 1'b1;
                        stateNext = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (outFire) begin
                        mainLoad  = 1'b1;
                        mainD     = skidQ;
                        skidClear = 1'b1;
                        stateNext = ST_ONE;
                    end
                end
                default: stateNext = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_EMPTY;
            inReadyReg <= 1'b1;
        end else begin
            state      <= stateNext;
            inReadyReg <= (stateNext != ST_FULL);
        end
    end

    pipe_slot #(.WIDTH(PAY_W)) mainSlot (
        .clock (clock),
        .reset (reset),
        .load  (mainLoad),
        .clear (mainClear),
        .dIn   (mainD),
        .valid (mainValid),
        .q     (mainQ)
    );

    generate
        if (SKID != 0) begin : genSkid
            pipe_slot #(.WIDTH(PAY_W)) skidSlot (
                .clock (clock),
                .reset (reset),
                .load  (skidLoad),
                .clear (skidClear),
                .dIn   (inPayload),
                .valid (skidValid),
                .q     (skidQ)
            );
        end else begin : genNoSkid
            assign skidValid = 1'b0;
            assign skidQ     = '0;
        end
    endgenerate

    assign out_valid = mainValid;
    assign out_ins   = mainValid ? mainQ[PAY_W-1 -: INS_W] : NOP_INS;
    assign out_pc    = mainQ[PC_LSB +: PC_W];
    assign out_data  = mainQ[FLAG_W +: DATA_ALL];
    assign out_flags = mainQ[FLAG_W-1:0];
    assign occupancy = skidValid ? 2'd2 : (mainValid ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: default skid stage, a reshaped-payload stage and a no-skid stage.
module tb_pipe_stage_reg;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // Stage A: defaults (SKID=1, 2x32-bit data)
    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aIns, aOutIns;
    logic [11:0] aPc, aOutPc;
    logic [63:0] aData, aOutData;
    logic [2:0]  aFlags, aOutFlags;
    logic [1:0]  aOcc;

    // Stage B: NOP=0x20, three 16-bit data channels
    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bIns, bOutIns;
    logic [11:0] bPc, bOutPc;
    logic [47:0] bData, bOutData;
    logic [2:0]  bFlags, bOutFlags;
    logic [1:0]  bOcc;

    // Stage C: SKID=0
    logic        cFlush, cInValid, cInReady, cOutValid, cOutReady;
    logic [31:0] cIns, cOutIns;
    logic [11:0] cPc, cOutPc;
    logic [63:0] cData, cOutData;
    logic [2:0]  cFlags, cOutFlags;
    logic [1:0]  cOcc;

    pipe_stage_reg dutA (
        .clock(clock), .reset(reset), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady), .in_ins(aIns), .in_pc(aPc),
        .in_data(aData), .in_flags(aFlags),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_ins(aOutIns), .out_pc(aOutPc),
        .out_data(aOutData), .out_flags(aOutFlags), .occupancy(aOcc)
    );

    pipe_stage_reg #(.NOP_INS(32'h00000020), .NUM_DATA(3), .DATA_W(16)) dutB (
        .clock(clock), .reset(reset), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady), .in_ins(bIns), .in_pc(bPc),
        .in_data(bData), .in_flags(bFlags),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_ins(bOutIns), .out_pc(bOutPc),
        .out_data(bOutData), .out_flags(bOutFlags), .occupancy(bOcc)
    );

    pipe_stage_reg #(.SKID(0)) dutC (
        .clock(clock), .reset(reset), .flush(cFlush),
        .in_valid(cInValid), .in_ready(cInReady), .in_ins(cIns), .in_pc(cPc),
        .in_data(cData), .in_flags(cFlags),
        .out_valid(cOutValid), .out_ready(cOutReady), .out_ins(cOutIns), .out_pc(cOutPc),
        .out_data(cOutData), .out_flags(cOutFlags), .occupancy(cOcc)
    );

    typedef struct packed {
        logic        inValid;
        logic [31:0] ins;
        logic        outReady;
        logic        flush;
        logic        expValid;
        logic [31:0] expIns;
        logic [1:0]  expOcc;
        logic        expReady;
    } vec_t;

    vec_t         vecs [17];
    logic [110:0] sb [$];
    int           nTests = 0;
    int           nFail  = 0;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic inValid, input logic [31:0] ins,
                                 input logic outReady, input logic fl);
        aInValid  = inValid;
        aIns      = ins;
        aPc       = ins[11:0];
        aData     = {ins, ~ins};
        aFlags    = ins[2:0];
        aOutReady = outReady;
        aFlush    = fl;
    endtask

    initial begin
        logic         expReady, inF, outF, rFlush;
        logic [110:0] entry;

        vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
        vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[4]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1};
        vecs[5]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        vecs[6]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[9]  = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1};
        vecs[10] = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd2, 1'b0};
        vecs[11] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 32'hB4, 1'b0, 1'b0, 1'b1, 32'hB4, 2'd1, 1'b1};
        vecs[13] = '{1'b1, 32'hB5, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1};
        vecs[15] = '{1'b1, 32'hC1, 1'b1, 1'b0, 1'b1, 32'hC1, 2'd1, 1'b1};
        vecs[16] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1};

        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        bFlush = 1'b0; bInValid = 1'b0; bOutReady = 1'b0;
        bIns = '0; bPc = '0; bData = '0; bFlags = '0;
        cFlush = 1'b0; cInValid = 1'b0; cOutReady = 1'b0;
        cIns = '0; cPc = '0; cData = '0; cFlags = '0;

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset out_valid", 128'(aOutValid), 128'(1'b0));
        checkOutput("reset out_ins", 128'(aOutIns), 128'(32'h0));
        checkOutput("reset occupancy", 128'(aOcc), 128'(2'd0));
        checkOutput("reset in_ready", 128'(aInReady), 128'(1'b1));

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].ins, vecs[i].outReady, vecs[i].flush);
            tick();
            checkOutput($sformatf("vec%0d out_valid", i), 128'(aOutValid), 128'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d out_ins", i), 128'(aOutIns), 128'(vecs[i].expIns));
            checkOutput($sformatf("vec%0d occupancy", i), 128'(aOcc), 128'(vecs[i].expOcc));
            checkOutput($sformatf("vec%0d in_ready", i), 128'(aInReady), 128'(vecs[i].expReady));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

        // Reshaped payload and custom NOP on stage B
        checkOutput("B idle out_ins", 128'(bOutIns), 128'(32'h00000020));
        bInValid = 1'b1; bIns = 32'h12345678; bPc = 12'hABC;
        bData = {16'h3333, 16'h2222, 16'h1111}; bFlags = 3'b101; bOutReady = 1'b1;
        tick();
        bInValid = 1'b0;
        checkOutput("B echo out_valid", 128'(bOutValid), 128'(1'b1));
        checkOutput("B echo out_ins", 128'(bOutIns), 128'(32'h12345678));
        checkOutput("B echo out_pc", 128'(bOutPc), 128'(12'hABC));
        checkOutput("B echo out_data", 128'(bOutData), 128'({16'h3333, 16'h2222, 16'h1111}));
        checkOutput("B echo out_flags", 128'(bOutFlags), 128'(3'b101));
        tick();
        checkOutput("B drained out_valid", 128'(bOutValid), 128'(1'b0));
        checkOutput("B drained out_ins", 128'(bOutIns), 128'(32'h00000020));

        // Combinational ready on the no-skid stage C
        cInValid = 1'b1; cIns = 32'hC0DE0001; cOutReady = 1'b0;
        tick();
        checkOutput("C loaded occupancy", 128'(cOcc), 128'(2'd1));
        checkOutput("C loaded out_ins", 128'(cOutIns), 128'(32'hC0DE0001));
        cIns = 32'hC0DE0002;
        #1;
        checkOutput("C stalled in_ready", 128'(cInReady), 128'(1'b0));
        cOutReady = 1'b1;
        #1;
        checkOutput("C released in_ready", 128'(cInReady), 128'(1'b1));
        tick();
        cInValid = 1'b0;
        checkOutput("C b2b out_ins", 128'(cOutIns), 128'(32'hC0DE0002));
        checkOutput("C b2b occupancy", 128'(cOcc), 128'(2'd1));
        tick();
        checkOutput("C drained out_valid", 128'(cOutValid), 128'(1'b0));
        checkOutput("C drained occupancy", 128'(cOcc), 128'(2'd0));

        // Reset wins over flush and a pending transfer with both slots full
        applyStimulus(1'b1, 32'hD1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'hD2, 1'b0, 1'b0);
        tick();
        checkOutput("pre-reset occupancy", 128'(aOcc), 128'(2'd2));
        applyStimulus(1'b1, 32'hD3, 1'b1, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("mid reset out_valid", 128'(aOutValid), 128'(1'b0));
        checkOutput("mid reset out_ins", 128'(aOutIns), 128'(32'h0));
        checkOutput("mid reset out_pc", 128'(aOutPc), 128'(12'h0));
        checkOutput("mid reset occupancy", 128'(aOcc), 128'(2'd0));
        checkOutput("mid reset in_ready", 128'(aInReady), 128'(1'b1));
        tick();
        checkOutput("post reset out_valid", 128'(aOutValid), 128'(1'b0));

        // Random traffic against a FIFO scoreboard
        sb.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rFlush    = ($urandom_range(0, 63) == 0);
            aInValid  = 1'($urandom_range(0, 1));
            aOutReady = ($urandom_range(0, 3) != 0);
            aFlush    = rFlush;
            aIns      = $urandom;
            aPc       = 12'($urandom);
            aData     = {$urandom, $urandom};
            aFlags    = 3'($urandom);
            #1;
            expReady = (sb.size() < 2);
            checkOutput("rand occupancy", 128'(aOcc), 128'(sb.size()));
            checkOutput("rand out_valid", 128'(aOutValid), 128'(sb.size() != 0));
            checkOutput("rand in_ready", 128'(aInReady), 128'(expReady));
            if (sb.size() != 0)
                checkOutput("rand payload", 128'({aOutIns, aOutPc, aOutData, aOutFlags}), 128'(sb[0]));
            else
                checkOutput("rand empty out_ins", 128'(aOutIns), 128'(32'h0));
            entry = {aIns, aPc, aData, aFlags};
            inF   = aInValid && expReady;
            outF  = (sb.size() != 0) && aOutReady;
            tick();
            if (outF) void'(sb.pop_front());
            if (rFlush) sb.delete();
            else if (inF) sb.push_back(entry);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
